// File: rtl/tile_draw_sequencer_pkg.sv
// Shared types and constants for the tile draw sequencer.
// Optional HIT_HIGHLIGHT_EN selects the hit colour for struck bottom tiles.
package tile_draw_sequencer_pkg;

  localparam int ROWS      = 6;
  localparam int LANES     = 4;
  localparam int ROW_PITCH = 40;

  localparam logic [2:0] COL_BG   = 3'b111;
  localparam logic [2:0] COL_TILE = 3'b000;
  localparam logic [2:0] COL_HIT  = 3'b001;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR_GO,
    S_CLR_GAP,
    S_BLK_SCAN,
    S_BLK_GO,
    S_BLK_GAP,
    S_ADVANCE,
    S_DONE
  } state_t;

  function automatic logic [2:0] lane_sanitize(
    input logic       valid,
    input logic [2:0] lane
  );
    if (valid && lane != 3'd0 && lane <= 3'(LANES))
      return lane;
    return 3'd0;
  endfunction

endpackage

// File: rtl/tile_draw_sequencer_row_store.sv
// Row store: six lane entries, scroll shift, hit flag and miss detection.
// HIT_HIGHLIGHT_EN picks the hit colour for a struck bottom-row tile.
module tile_draw_sequencer_row_store
  import tile_draw_sequencer_pkg::*;
(
  input  logic       clock,
  input  logic       resetn,
  input  logic       i_shift,
  input  logic [2:0] i_lane,
  input  logic       i_lane_valid,
  input  logic       i_hit,
  input  logic [2:0] i_rd_addr,
  output logic [2:0] o_rd_data,
  output logic [2:0] o_rd_colour,
  output logic       o_miss,
  output logic       o_ready
);

  logic [ROWS-1:0][2:0] r_rows;
  logic                 r_hit_flag;
  logic                 r_miss;
  logic                 r_ready;
  logic                 w_row0_live;

  assign w_row0_live = (r_rows[0] != 3'd0);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_rows     <= '0;
      r_hit_flag <= 1'b0;
      r_miss     <= 1'b0;
      r_ready    <= 1'b0;
    end else begin
      r_miss  <= 1'b0;
      r_ready <= 1'b0;
      if (i_shift) begin
        r_rows     <= {lane_sanitize(i_lane_valid, i_lane),
                       r_rows[ROWS-1:1]};
        r_miss     <= w_row0_live && !r_hit_flag;
        r_ready    <= i_lane_valid;
        r_hit_flag <= 1'b0;
      end else if (i_hit && w_row0_live) begin
        r_hit_flag <= 1'b1;
      end
    end
  end

  assign o_rd_data = (i_rd_addr < 3'(ROWS)) ? r_rows[i_rd_addr] : 3'd0;

`ifdef HIT_HIGHLIGHT_EN
  assign o_rd_colour = (i_rd_addr == 3'd0 && r_hit_flag) ? COL_HIT
                                                          : COL_TILE;
`else
  assign o_rd_colour = (r_hit_flag && 1'b0) ? COL_HIT : COL_TILE;
`endif

  assign o_miss  = r_miss;
  assign o_ready = r_ready;

endmodule

// File: rtl/tile_draw_sequencer.sv
// Per-frame sequencer: clear four lanes, draw live tiles, then scroll.
// HIT_HIGHLIGHT_EN (in row store) draws a struck bottom tile in the hit colour.
module tile_draw_sequencer
  import tile_draw_sequencer_pkg::*;
(
  input  logic       clock,
  input  logic       resetn,
  input  logic       frame_tick,
  input  logic [1:0] speed,
  input  logic [2:0] new_lane,
  input  logic       new_lane_valid,
  output logic       new_lane_ready,
  input  logic       hit,
  output logic       line_go,
  input  logic       line_done,
  output logic [2:0] line_6,
  output logic       block_go,
  input  logic       block_done,
  output logic [2:0] block_line_id,
  output logic [2:0] block_row,
  output logic [5:0] offset,
  output logic [2:0] colour,
  output logic       busy,
  output logic       frame_done,
  output logic       miss
);

  state_t     r_state;
  logic [2:0] r_lane_cnt;
  logic [2:0] r_row_cnt;
  logic       r_pending;
  logic [5:0] r_offset;
  logic       r_line_go;
  logic [2:0] r_line_6;
  logic       r_block_go;
  logic [2:0] r_block_line_id;
  logic [2:0] r_block_row;
  logic [2:0] r_colour;
  logic       r_busy;
  logic       r_frame_done;

  logic [6:0] w_sum;
  logic       w_wrap;
  logic [5:0] w_off_next;
  logic       w_shift;
  logic [2:0] w_rd_data;
  logic [2:0] w_rd_colour;

  assign w_sum      = {1'b0, r_offset} + 7'(speed);
  assign w_wrap     = (w_sum >= 7'(ROW_PITCH));
  assign w_off_next = 6'(w_wrap ? w_sum - 7'(ROW_PITCH) : w_sum);
  assign w_shift    = (r_state == S_ADVANCE) && w_wrap;

  tile_draw_sequencer_row_store u_rows (
    .clock        (clock),
    .resetn       (resetn),
    .i_shift      (w_shift),
    .i_lane       (new_lane),
    .i_lane_valid (new_lane_valid),
    .i_hit        (hit),
    .i_rd_addr    (r_row_cnt),
    .o_rd_data    (w_rd_data),
    .o_rd_colour  (w_rd_colour),
    .o_miss       (miss),
    .o_ready      (new_lane_ready)
  );

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state         <= S_IDLE;
      r_lane_cnt      <= 3'd0;
      r_row_cnt       <= 3'd0;
      r_pending       <= 1'b0;
      r_offset        <= 6'd0;
      r_line_go       <= 1'b0;
      r_line_6        <= 3'd1;
      r_block_go      <= 1'b0;
      r_block_line_id <= 3'd0;
      r_block_row     <= 3'd0;
      r_colour        <= COL_BG;
      r_busy          <= 1'b0;
      r_frame_done    <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      // A tick while a pass runs is remembered once; extras are dropped.
      if (frame_tick && r_state != S_IDLE)
        r_pending <= 1'b1;
      unique case (r_state)
        S_IDLE: begin
          if (frame_tick || r_pending) begin
            r_pending  <= 1'b0;
            r_lane_cnt <= 3'd1;
            r_line_6   <= 3'd1;
            r_line_go  <= 1'b1;
            r_colour   <= COL_BG;
            r_busy     <= 1'b1;
            r_state    <= S_CLR_GO;
          end
        end
        S_CLR_GO: begin
          if (line_done) begin
            r_line_go <= 1'b0;
            r_state   <= S_CLR_GAP;
          end
        end
        S_CLR_GAP: begin
          if (r_lane_cnt < 3'(LANES)) begin
            r_lane_cnt <= r_lane_cnt + 3'd1;
            r_line_6   <= r_lane_cnt + 3'd1;
            r_line_go  <= 1'b1;
            r_colour   <= COL_BG;
            r_state    <= S_CLR_GO;
          end else begin
            r_row_cnt <= 3'd0;
            r_state   <= S_BLK_SCAN;
          end
        end
        S_BLK_SCAN: begin
          if (r_row_cnt >= 3'(ROWS)) begin
            r_state <= S_ADVANCE;
          end else if (w_rd_data == 3'd0) begin
            r_row_cnt <= r_row_cnt + 3'd1;
          end else begin
            r_block_go      <= 1'b1;
            r_block_line_id <= w_rd_data;
            r_block_row     <= r_row_cnt;
            r_colour        <= w_rd_colour;
            r_state         <= S_BLK_GO;
          end
        end
        S_BLK_GO: begin
          if (block_done) begin
            r_block_go <= 1'b0;
            r_state    <= S_BLK_GAP;
          end
        end
        S_BLK_GAP: begin
          r_row_cnt <= r_row_cnt + 3'd1;
          r_state   <= S_BLK_SCAN;
        end
        S_ADVANCE: begin
          r_offset     <= w_off_next;
          r_frame_done <= 1'b1;
          r_state      <= S_DONE;
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign line_go       = r_line_go;
  assign line_6        = r_line_6;
  assign block_go      = r_block_go;
  assign block_line_id = r_block_line_id;
  assign block_row     = r_block_row;
  assign offset        = r_offset;
  assign colour        = r_colour;
  assign busy          = r_busy;
  assign frame_done    = r_frame_done;

endmodule

// File: tb/tb_tile_draw_sequencer.sv
// Bench for tile_draw_sequencer: directed pass table, corner sequences,
// and randomized passes against a row/offset reference model.
module tb_tile_draw_sequencer;

  logic       clock;
  logic       resetn;
  logic       frame_tick;
  logic [1:0] speed;
  logic [2:0] new_lane;
  logic       new_lane_valid;
  logic       new_lane_ready;
  logic       hit;
  logic       line_go;
  logic       line_done;
  logic [2:0] line_6;
  logic       block_go;
  logic       block_done;
  logic [2:0] block_line_id;
  logic [2:0] block_row;
  logic [5:0] offset;
  logic [2:0] colour;
  logic       busy;
  logic       frame_done;
  logic       miss;

  tile_draw_sequencer dut (
    .clock          (clock),
    .resetn         (resetn),
    .frame_tick     (frame_tick),
    .speed          (speed),
    .new_lane       (new_lane),
    .new_lane_valid (new_lane_valid),
    .new_lane_ready (new_lane_ready),
    .hit            (hit),
    .line_go        (line_go),
    .line_done      (line_done),
    .line_6         (line_6),
    .block_go       (block_go),
    .block_done     (block_done),
    .block_line_id  (block_line_id),
    .block_row      (block_row),
    .offset         (offset),
    .colour         (colour),
    .busy           (busy),
    .frame_done     (frame_done),
    .miss           (miss)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef struct packed {
    logic [2:0] id;
    logic [2:0] row;
    logic [2:0] col;
  } rec_t;

  typedef struct {
    int spd; int lane; int vld; int hit; int n;
    int off; int rdy; int mis;
  } vec_t;

  int checks = 0;
  int errors = 0;
  int fd_cnt = 0, miss_cnt = 0, rdy_cnt = 0;
  int ovl_err = 0, reassert_err = 0;
  rec_t clr_q[$];
  rec_t blk_q[$];

  int m_rows[6];
  int m_off;
  bit m_hit;

  // Engine responders plus pulse counters, all at the falling edge.
  initial begin
    line_done  = 1'b0;
    block_done = 1'b0;
    forever begin
      @(negedge clock);
      if (line_go && block_go) ovl_err++;
      if (frame_done) fd_cnt++;
      if (miss) miss_cnt++;
      if (new_lane_ready) rdy_cnt++;
      if (!resetn) begin
        line_done  = 1'b0;
        block_done = 1'b0;
      end else begin
        if (line_done) begin
          if (line_go) reassert_err++;
          line_done = 1'b0;
        end else if (line_go && $urandom_range(0, 2) == 0) begin
          line_done = 1'b1;
          clr_q.push_back('{line_6, 3'd0, colour});
        end
        if (block_done) begin
          if (block_go) reassert_err++;
          block_done = 1'b0;
        end else if (block_go && $urandom_range(0, 2) == 0) begin
          block_done = 1'b1;
          blk_q.push_back('{block_line_id, block_row, colour});
        end
      end
    end
  end

  task automatic step();
    @(negedge clock);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    foreach (m_rows[i]) m_rows[i] = 0;
    m_off = 0;
    m_hit = 1'b0;
  endtask

  task automatic model_advance(input int spd, input int lane, input int vld,
                               output int em, output int er);
    int sum;
    sum = m_off + spd;
    em = 0;
    er = 0;
    if (sum >= 40) begin
      m_off = sum - 40;
      em = (m_rows[0] != 0 && !m_hit) ? 1 : 0;
      er = vld;
      for (int i = 0; i < 5; i++) m_rows[i] = m_rows[i + 1];
      m_rows[5] = (vld != 0 && lane >= 1 && lane <= 4) ? lane : 0;
      m_hit = 1'b0;
    end else begin
      m_off = sum;
    end
  endtask

  task automatic run_pass(input int spd, input int lane, input int vld,
                          input int dohit, output int dmiss, output int drdy);
    int fd0, mi0, rd0, k, ecol, em, er, nb;
    rec_t exp_b[$];
    if (dohit != 0) begin
      hit = 1'b1;
      step();
      hit = 1'b0;
      if (m_rows[0] != 0) m_hit = 1'b1;
    end
    speed          = 2'(spd);
    new_lane       = 3'(lane);
    new_lane_valid = 1'(vld);
    clr_q.delete();
    blk_q.delete();
    fd0 = fd_cnt;
    mi0 = miss_cnt;
    rd0 = rdy_cnt;
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    k = 0;
    while (fd_cnt == fd0 && k < 3000) begin
      step();
      k++;
    end
    step();
    step();
    for (int r = 0; r < 6; r++) begin
      if (m_rows[r] != 0) begin
`ifdef HIT_HIGHLIGHT_EN
        ecol = (r == 0 && m_hit) ? 1 : 0;
`else
        ecol = 0;
`endif
        exp_b.push_back('{3'(m_rows[r]), 3'(r), 3'(ecol)});
      end
    end
    model_advance(spd, lane, vld, em, er);
    chk("frame_done_pulses", fd_cnt - fd0, 1);
    chk("clear_count", clr_q.size(), 4);
    foreach (clr_q[i]) begin
      chk("clear_lane", clr_q[i].id, i + 1);
      chk("clear_colour", clr_q[i].col, 7);
    end
    chk("block_count", blk_q.size(), exp_b.size());
    nb = (blk_q.size() < exp_b.size()) ? blk_q.size() : exp_b.size();
    for (int i = 0; i < nb; i++) begin
      chk("block_lane", blk_q[i].id, exp_b[i].id);
      chk("block_row", blk_q[i].row, exp_b[i].row);
      chk("block_colour", blk_q[i].col, exp_b[i].col);
    end
    chk("offset", offset, m_off);
    chk("miss_pulses", miss_cnt - mi0, em);
    chk("ready_pulses", rdy_cnt - rd0, er);
    chk("busy_after", busy, 0);
    dmiss = miss_cnt - mi0;
    drdy  = rdy_cnt - rd0;
  endtask

  vec_t tbl[14];

  initial begin
    int dm, dr, tm, tr, k, fd0, mi0, em1, er1, em2, er2;
    tbl[0]  = '{2, 0, 0, 0,  1,  2, 0, 0};
    tbl[1]  = '{0, 0, 0, 0,  1,  2, 0, 0};
    tbl[2]  = '{3, 2, 1, 0, 13,  1, 1, 0};
    tbl[3]  = '{3, 0, 1, 0, 13,  0, 1, 0};
    tbl[4]  = '{3, 4, 1, 0, 14,  2, 1, 0};
    tbl[5]  = '{3, 7, 1, 0, 13,  1, 1, 0};
    tbl[6]  = '{3, 5, 0, 0, 13,  0, 0, 0};
    tbl[7]  = '{3, 1, 1, 0, 14,  2, 1, 0};
    tbl[8]  = '{0, 0, 0, 0,  1,  2, 0, 0};
    tbl[9]  = '{3, 0, 0, 0, 12, 38, 0, 0};
    tbl[10] = '{3, 3, 1, 0,  1,  1, 1, 1};
    tbl[11] = '{3, 0, 0, 0, 13,  0, 0, 0};
    tbl[12] = '{0, 0, 0, 1,  1,  0, 0, 0};
    tbl[13] = '{3, 2, 1, 1, 14,  2, 1, 0};

    resetn = 1'b0;
    frame_tick = 1'b0;
    speed = 2'd0;
    new_lane = 3'd0;
    new_lane_valid = 1'b0;
    hit = 1'b0;
    model_reset();
    repeat (3) step();
    chk("rst_line_go", line_go, 0);
    chk("rst_block_go", block_go, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_miss", miss, 0);
    chk("rst_ready", new_lane_ready, 0);
    chk("rst_line_6", line_6, 1);
    chk("rst_block_line_id", block_line_id, 0);
    chk("rst_block_row", block_row, 0);
    chk("rst_colour", colour, 7);
    chk("rst_offset", offset, 0);
    resetn = 1'b1;
    step();

    for (int t = 0; t < 14; t++) begin
      tm = 0;
      tr = 0;
      for (int p = 0; p < tbl[t].n; p++) begin
        run_pass(tbl[t].spd, tbl[t].lane, tbl[t].vld, tbl[t].hit, dm, dr);
        tm += dm;
        tr += dr;
      end
      chk("tbl_offset", offset, tbl[t].off);
      chk("tbl_ready", tr, tbl[t].rdy);
      chk("tbl_miss", tm, tbl[t].mis);
    end

    // Three ticks while one pass runs: exactly one follow-up pass.
    speed = 2'd1;
    new_lane = 3'd0;
    new_lane_valid = 1'b0;
    fd0 = fd_cnt;
    mi0 = miss_cnt;
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    step();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    step();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    k = 0;
    while (fd_cnt - fd0 < 2 && k < 6000) begin
      step();
      k++;
    end
    repeat (200) step();
    model_advance(1, 0, 0, em1, er1);
    model_advance(1, 0, 0, em2, er2);
    chk("pending_passes", fd_cnt - fd0, 2);
    chk("pending_offset", offset, m_off);
    chk("pending_miss", miss_cnt - mi0, em1 + em2);

    // Reset while a tile draw is in flight.
    speed = 2'd0;
    fd0 = fd_cnt;
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    k = 0;
    while (!block_go && k < 500) begin
      step();
      k++;
    end
    chk("midpass_block_go_seen", block_go, 1);
    resetn = 1'b0;
    #1;
    chk("midpass_rst_block_go", block_go, 0);
    chk("midpass_rst_busy", busy, 0);
    chk("midpass_rst_colour", colour, 7);
    repeat (3) step();
    chk("midpass_no_frame_done", fd_cnt - fd0, 0);
    chk("midpass_rst_offset", offset, 0);
    resetn = 1'b1;
    step();
    model_reset();
    run_pass(0, 0, 0, 0, dm, dr);

    for (int n = 0; n < 250; n++) begin
      run_pass($urandom_range(0, 3), $urandom_range(0, 7),
               $urandom_range(0, 1), $urandom_range(0, 1), dm, dr);
    end

    chk("go_overlap", ovl_err, 0);
    chk("go_reasserted_on_done", reassert_err, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
